// File: rtl/h2c_packer.sv
`default_nettype none
// ============================================================================
// Module   : h2c_packer
// Purpose  : Packs a 64-bit H2C AXI-Stream into 128-bit RAM words. The RAM is
//            split into 8 slots of SLOT_WORDS words, filled in round-robin
//            order. Each completed packet marks its slot busy (DataValid),
//            reports its word count (WrLen/LenValid), and holds the slot until
//            the consumer releases it with a RamValid pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   s_tdata/s_tkeep/s_tlast/s_tvalid/s_tready : AXI-Stream sink (64-bit)
//   WrData/WrEn/WrAddr: RAM write port, 128-bit data, word address
//   DataValid[7:0]    : bit i set = slot i holds a complete packet
//   RamValid[7:0]     : one-cycle pulse on bit i releases slot i
//   WrLen/LenValid    : word count of the last packet, strobed in DONE
//   ErrOvf            : one-cycle strobe when a word is dropped for overflow
// ============================================================================
module h2c_packer #(
  parameter int unsigned SLOT_WORDS = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  s_tdata,
  input  logic [7:0]   s_tkeep,
  input  logic         s_tlast,
  input  logic         s_tvalid,
  output logic         s_tready,
  output logic [127:0] WrData,
  output logic         WrEn,
  output logic [31:0]  WrAddr,
  output logic [7:0]   DataValid,
  input  logic [7:0]   RamValid,
  output logic [15:0]  WrLen,
  output logic         LenValid,
  output logic         ErrOvf
);

  localparam int unsigned SLOT_BITS = $clog2(SLOT_WORDS);
  // One extra bit so the counter can hold SLOT_WORDS itself (slot full).
  localparam int unsigned CNT_W     = SLOT_BITS + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             next_state;

  logic [2:0]         cur_slot;
  logic [CNT_W-1:0]   word_cnt;
  logic [63:0]        low_word;
  logic               ready_ok;
  logic [7:0]         data_valid_q;
  logic [15:0]        len_q;
  logic               wr_en_q;
  logic [127:0]       wr_data_q;
  logic [31:0]        wr_addr_q;
  logic               err_q;

  logic               ready_c;
  logic               word_due;
  logic [127:0]       word_next;
  logic [63:0]        beat_masked;
  logic               cnt_full;
  logic [31:0]        addr_next;
  logic [15:0]        len_ext;
  logic [7:0]         done_mask;

  // --------------------------------------------------------------------------
  // Next-state and handshake decode. s_tready depends on state only, so there
  // is no combinational path from s_tvalid to s_tready.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state  = state;
    ready_c     = 1'b0;
    word_due    = 1'b0;
    word_next   = '0;
    beat_masked = '0;

    for (int i = 0; i < 8; i++) begin
      beat_masked[8*i +: 8] = s_tkeep[i] ? s_tdata[8*i +: 8] : 8'h00;
    end

    case (state)
      IDLE: begin
        // ready_ok delays the first ready by one cycle after reset release.
        if (ready_ok && !data_valid_q[cur_slot]) begin
          next_state = LOW;
        end
      end
      LOW: begin
        ready_c = 1'b1;
        if (s_tvalid) begin
          if (s_tlast) begin
            word_due   = 1'b1;
            word_next  = {64'h0, beat_masked};
            next_state = DONE;
          end else begin
            next_state = HIGH;
          end
        end
      end
      HIGH: begin
        ready_c = 1'b1;
        if (s_tvalid) begin
          word_due   = 1'b1;
          word_next  = {beat_masked, low_word};
          next_state = s_tlast ? DONE : LOW;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  assign cnt_full  = (word_cnt == CNT_W'(SLOT_WORDS));
  assign addr_next = BASE_ADDR + (32'(cur_slot) << SLOT_BITS) + 32'(word_cnt);
  assign len_ext   = 16'(word_cnt);
  assign done_mask = (state == DONE) ? (8'b1 << cur_slot) : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_slot     <= '0;
      word_cnt     <= '0;
      low_word     <= '0;
      ready_ok     <= 1'b0;
      data_valid_q <= '0;
      len_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      ready_ok <= 1'b1;
      wr_en_q  <= 1'b0;
      err_q    <= 1'b0;

      if (state == LOW && s_tvalid) begin
        low_word <= beat_masked;
      end

      // A full slot swallows further words; the packet still runs to tlast.
      if (word_due) begin
        if (cnt_full) begin
          err_q <= 1'b1;
        end else begin
          wr_en_q   <= 1'b1;
          wr_data_q <= word_next;
          wr_addr_q <= addr_next;
          word_cnt  <= word_cnt + CNT_W'(1);
        end
      end

      if (state == DONE) begin
        len_q    <= len_ext;
        cur_slot <= cur_slot + 3'd1;
        word_cnt <= '0;
      end

      // Release first, then set: a set in DONE wins over a same-cycle release.
      data_valid_q <= (data_valid_q & ~RamValid) | done_mask;
    end
  end

  assign s_tready  = ready_c;
  assign WrEn      = wr_en_q;
  assign WrData    = wr_data_q;
  assign WrAddr    = wr_addr_q;
  assign ErrOvf    = err_q;
  assign DataValid = data_valid_q;
  assign LenValid  = (state == DONE);
  assign WrLen     = (state == DONE) ? len_ext : len_q;

endmodule
`default_nettype wire

// File: tb/tb_h2c_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_h2c_packer
// Purpose  : Directed, table-driven bench for h2c_packer (SLOT_WORDS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_h2c_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  s_tdata;
  logic [7:0]   s_tkeep;
  logic         s_tlast;
  logic         s_tvalid;
  logic         s_tready;
  logic [127:0] WrData;
  logic         WrEn;
  logic [31:0]  WrAddr;
  logic [7:0]   DataValid;
  logic [7:0]   RamValid;
  logic [15:0]  WrLen;
  logic         LenValid;
  logic         ErrOvf;

  int total  = 0;
  int passed = 0;

  h2c_packer #(.SLOT_WORDS(4), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .WrData(WrData), .WrEn(WrEn), .WrAddr(WrAddr),
    .DataValid(DataValid), .RamValid(RamValid),
    .WrLen(WrLen), .LenValid(LenValid), .ErrOvf(ErrOvf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  data;
    logic [7:0]   keep;
    logic         last;
    logic         exp_we;
    logic [127:0] exp_wdata;
    logic [31:0]  exp_waddr;
    logic         exp_err;
    logic [15:0]  exp_len;
    logic [7:0]   rv_done;   // RamValid driven during the DONE cycle
    logic [7:0]   exp_dv;    // DataValid after DONE
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [63:0] d, logic [7:0] k, logic l,
                              logic we, logic [127:0] wd, logic [31:0] wa,
                              logic er, logic [15:0] len, logic [7:0] rv,
                              logic [7:0] dv);
    vec_t v;
    v.data = d; v.keep = k; v.last = l; v.exp_we = we; v.exp_wdata = wd;
    v.exp_waddr = wa; v.exp_err = er; v.exp_len = len; v.rv_done = rv;
    v.exp_dv = dv;
    return v;
  endfunction

  function automatic vec_t mid(logic [63:0] d, logic [7:0] k);
    return mk(d, k, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted
  // (or after DONE when the beat carries tlast).
  task automatic apply(input vec_t v, input string tag);
    int n;
    n = 0;
    s_tdata  = v.data;
    s_tkeep  = v.keep;
    s_tlast  = v.last;
    s_tvalid = 1'b1;
    while (s_tready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (s_tready !== 1'b1) begin
      total++;
      $display("FAIL %s_accept: s_tready stayed %b, required 1 within 200 cycles", tag, s_tready);
      s_tvalid = 1'b0;
      return;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    chk({tag, "_wren"}, WrEn, v.exp_we);
    chk({tag, "_errovf"}, ErrOvf, v.exp_err);
    if (v.exp_we) begin
      chk({tag, "_wrdata"}, WrData, v.exp_wdata);
      chk({tag, "_wraddr"}, WrAddr, v.exp_waddr);
    end
    if (v.last) begin
      chk({tag, "_lenvalid"}, LenValid, 1'b1);
      chk({tag, "_wrlen"}, WrLen, v.exp_len);
      RamValid = v.rv_done;
      @(negedge clk);
      RamValid = 8'h00;
      chk({tag, "_datavalid"}, DataValid, v.exp_dv);
    end else begin
      chk({tag, "_lenvalid"}, LenValid, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tready"},   s_tready,  1'b0);
    chk({tag, "_wren"},     WrEn,      1'b0);
    chk({tag, "_wraddr"},   WrAddr,    32'h0);
    chk({tag, "_wrdata"},   WrData,    128'h0);
    chk({tag, "_datavalid"}, DataValid, 8'h00);
    chk({tag, "_wrlen"},    WrLen,     16'h0);
    chk({tag, "_lenvalid"}, LenValid,  1'b0);
    chk({tag, "_errovf"},   ErrOvf,    1'b0);
  endtask

  localparam logic [63:0] C1 = 64'h0C00_0000_0000_0001;

  initial begin
    int stall_seen;
    rst = 1'b1; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    RamValid = 8'h00;

    // Packet A, slot 0: four full beats
    vecs.push_back(mid(64'h1, 8'hFF));
    vecs.push_back(mk(64'h2, 8'hFF, 0, 1, {64'h2, 64'h1}, 32'd0, 0, 0, 0, 0));
    vecs.push_back(mid(64'h3, 8'hFF));
    vecs.push_back(mk(64'h4, 8'hFF, 1, 1, {64'h4, 64'h3}, 32'd1, 0, 16'd2, 8'h00, 8'h01));
    // Packet B, slot 1: odd beat count, last beat keeps low 4 bytes
    vecs.push_back(mid(64'h5, 8'hFF));
    vecs.push_back(mk(64'h6, 8'hFF, 0, 1, {64'h6, 64'h5}, 32'd4, 0, 0, 0, 0));
    vecs.push_back(mk(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1, 1,
                      {64'h0, 64'h0000_0000_FFFF_FFFF}, 32'd5, 0, 16'd2, 8'h00, 8'h03));
    // Packet C, slot 2: 10 beats into a 4-word slot, partial keeps on beats 3/4
    vecs.push_back(mid(C1, 8'hFF));
    vecs.push_back(mk(C1 + 1, 8'hFF, 0, 1, {C1 + 64'd1, C1}, 32'd8, 0, 0, 0, 0));
    vecs.push_back(mid(C1 + 2, 8'h01));
    vecs.push_back(mk(C1 + 3, 8'h80, 0, 1, {64'h0C00_0000_0000_0000, 64'h3}, 32'd9, 0, 0, 0, 0));
    vecs.push_back(mid(C1 + 4, 8'hFF));
    vecs.push_back(mk(C1 + 5, 8'hFF, 0, 1, {C1 + 64'd5, C1 + 64'd4}, 32'd10, 0, 0, 0, 0));
    vecs.push_back(mid(C1 + 6, 8'hFF));
    vecs.push_back(mk(C1 + 7, 8'hFF, 0, 1, {C1 + 64'd7, C1 + 64'd6}, 32'd11, 0, 0, 0, 0));
    vecs.push_back(mid(C1 + 8, 8'hFF));
    vecs.push_back(mk(C1 + 9, 8'hFF, 1, 0, '0, '0, 1, 16'd4, 8'h00, 8'h07));
    // Packet D, slot 3: single beat; RamValid[3] (set wins) and RamValid[5] (clear bit) in DONE
    vecs.push_back(mk(64'hDEAD_BEEF_0123_4567, 8'hFF, 1, 1,
                      {64'h0, 64'hDEAD_BEEF_0123_4567}, 32'd12, 0, 16'd1, 8'h28, 8'h0F));
    // Slots 4..7
    vecs.push_back(mid(64'h4A, 8'hFF));
    vecs.push_back(mk(64'h4B, 8'h00, 1, 1, {64'h0, 64'h4A}, 32'd16, 0, 16'd1, 8'h00, 8'h1F));
    vecs.push_back(mid(64'h5A, 8'hFF));
    vecs.push_back(mk(64'h5B, 8'hFF, 1, 1, {64'h5B, 64'h5A}, 32'd20, 0, 16'd1, 8'h00, 8'h3F));
    vecs.push_back(mid(64'h6A, 8'hFF));
    vecs.push_back(mk(64'h6B, 8'hFF, 0, 1, {64'h6B, 64'h6A}, 32'd24, 0, 0, 0, 0));
    vecs.push_back(mk(64'h6C, 8'hFF, 1, 1, {64'h0, 64'h6C}, 32'd25, 0, 16'd2, 8'h00, 8'h7F));
    vecs.push_back(mid(64'h7A, 8'hFF));
    vecs.push_back(mk(64'h7B, 8'hFF, 1, 1, {64'h7B, 64'h7A}, 32'd28, 0, 16'd1, 8'h00, 8'hFF));

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", s_tready, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Ninth packet: all slots busy, so ready must stay low until slot 0 frees
    s_tdata = 64'h9A; s_tkeep = 8'hFF; s_tlast = 1'b0; s_tvalid = 1'b1;
    stall_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_tready !== 1'b0) stall_seen++;
    end
    chk("stall_ready_low", stall_seen, 0);
    RamValid = 8'h01;
    @(negedge clk);
    RamValid = 8'h00;
    chk("release_slot0", DataValid, 8'hFE);
    apply(mid(64'h9A, 8'hFF), "p9_b0");
    apply(mk(64'h9B, 8'hFF, 1, 1, {64'h9B, 64'h9A}, 32'd0, 0, 16'd1, 8'h00, 8'hFF), "p9_b1");

    // Reset in the middle of a packet headed for slot 1
    RamValid = 8'h02;
    @(negedge clk);
    RamValid = 8'h00;
    chk("release_slot1", DataValid, 8'hFD);
    apply(mid(64'h11, 8'hFF), "rp_b0");
    apply(mk(64'h12, 8'hFF, 0, 1, {64'h12, 64'h11}, 32'd4, 0, 0, 0, 0), "rp_b1");
    apply(mid(64'h13, 8'hFF), "rp_b2");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    apply(mid(64'h21, 8'hFF), "post_b0");
    apply(mk(64'h22, 8'hFF, 1, 1, {64'h22, 64'h21}, 32'd0, 0, 16'd1, 8'h00, 8'h01), "post_b1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute guard so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t, required finish before 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
